// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
//   Sequences every access on the single shared memory bus. Instruction
//   fetches use the PC and data loads/stores use the ALU address; addr_sel
//   drives the addr_mux2 select (0 = PC, 1 = data address). The block runs the
//   mem_req/mem_ready handshake with a wait-state timeout and captures read
//   data into the instruction and load registers.
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   fetch_req             pulse: fetch at the current PC
//   ls_req, ls_write      pulse: data access (ls_write 1 = store, 0 = load)
//   ls_wdata              store data, sampled with ls_req
//   mem_ready, mem_rdata  memory completion and read data
//   addr_sel              address mux select
//   mem_req, mem_we       access in progress, store strobe
//   mem_wdata             latched store data
//   instr, instr_valid    last fetched instruction, one-cycle update pulse
//   load_data, ls_done    last load data, one-cycle load/store done pulse
//   bus_error             one-cycle pulse on timeout abort
//   busy                  controller is not idle
module mem_access_ctrl #(
    parameter int ADDRESS_BUS_WIDTH = 16,
    parameter int DATA_BUS_WIDTH    = 16,
    parameter int MAX_WAIT          = 15
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      fetch_req,
    input  logic                      ls_req,
    input  logic                      ls_write,
    input  logic [DATA_BUS_WIDTH-1:0] ls_wdata,
    input  logic                      mem_ready,
    input  logic [DATA_BUS_WIDTH-1:0] mem_rdata,
    output logic                      addr_sel,
    output logic                      mem_req,
    output logic                      mem_we,
    output logic [DATA_BUS_WIDTH-1:0] mem_wdata,
    output logic [DATA_BUS_WIDTH-1:0] instr,
    output logic                      instr_valid,
    output logic [DATA_BUS_WIDTH-1:0] load_data,
    output logic                      ls_done,
    output logic                      bus_error,
    output logic                      busy
);

    // The address itself is muxed outside; the width is only sanity-checked.
    if (ADDRESS_BUS_WIDTH < 1 || DATA_BUS_WIDTH < 1 || MAX_WAIT < 0) begin : g_param_chk
        $error("mem_access_ctrl: bad parameter value");
    end

    localparam int WCW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    // wait_cnt holds the number of earlier low-ready cycles, so reaching
    // MAX_WAIT-1 with ready still low means this is access cycle MAX_WAIT.
    localparam logic [WCW-1:0] WAIT_LAST = WCW'((MAX_WAIT > 0) ? MAX_WAIT - 1 : 0);

    typedef enum logic [1:0] {IDLE, IFETCH, DACCESS} state_t;

    state_t         state;
    logic           fetch_pend;
    logic [WCW-1:0] wait_cnt;
    logic           timeout;

    assign timeout = (MAX_WAIT != 0) && (wait_cnt == WAIT_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            fetch_pend  <= 1'b0;
            wait_cnt    <= '0;
            addr_sel    <= 1'b0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_wdata   <= '0;
            instr       <= '0;
            instr_valid <= 1'b0;
            load_data   <= '0;
            ls_done     <= 1'b0;
            bus_error   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            instr_valid <= 1'b0;
            ls_done     <= 1'b0;
            bus_error   <= 1'b0;
            case (state)
                IDLE: begin
                    // A pending fetch owns this IDLE cycle; new requests are dropped.
                    if (fetch_pend) begin
                        state      <= IFETCH;
                        fetch_pend <= 1'b0;
                        wait_cnt   <= '0;
                        mem_req    <= 1'b1;
                        addr_sel   <= 1'b0;
                        mem_we     <= 1'b0;
                        busy       <= 1'b1;
                    end else if (ls_req) begin
                        // Data access wins; a simultaneous fetch is remembered.
                        state      <= DACCESS;
                        fetch_pend <= fetch_req;
                        wait_cnt   <= '0;
                        mem_req    <= 1'b1;
                        addr_sel   <= 1'b1;
                        mem_we     <= ls_write;
                        mem_wdata  <= ls_wdata;
                        busy       <= 1'b1;
                    end else if (fetch_req) begin
                        state    <= IFETCH;
                        wait_cnt <= '0;
                        mem_req  <= 1'b1;
                        addr_sel <= 1'b0;
                        mem_we   <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                IFETCH, DACCESS: begin
                    if (mem_ready || timeout) begin
                        if (!mem_ready) begin
                            bus_error <= 1'b1;
                        end else if (state == IFETCH) begin
                            instr       <= mem_rdata;
                            instr_valid <= 1'b1;
                        end else begin
                            if (!mem_we) load_data <= mem_rdata;
                            ls_done <= 1'b1;
                        end
                        state    <= IDLE;
                        mem_req  <= 1'b0;
                        mem_we   <= 1'b0;
                        addr_sel <= 1'b0;
                        busy     <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    mem_req  <= 1'b0;
                    mem_we   <= 1'b0;
                    addr_sel <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule
